// File: rtl/add_minus.sv
// Registered two's-complement adder/subtractor with carry and overflow flags.
// m=0 computes A + B; m=1 computes A - B as A + ~B + 1 through a ripple chain.
module add_minus #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             m,
  output logic [WIDTH-1:0] S,
  output logic             c,
  output logic             v
);

  // Effective B operand, ripple carries and raw sum of the chain.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] sum;

  // Subtract is add with inverted B and a carry-in of one.
  assign cy[0] = m;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    // One full adder stage of the ripple chain.
    assign b_eff[i]  = B[i] ^ m;
    assign sum[i]    = A[i] ^ b_eff[i] ^ cy[i];
    assign cy[i+1]   = (A[i] & b_eff[i]) | (cy[i] & (A[i] ^ b_eff[i]));
  end

  // Output registers: load result and flags each edge, clear asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S <= '0;
      c <= 1'b0;
      v <= 1'b0;
    end else begin
      S <= sum;
      c <= cy[WIDTH];
      v <= cy[WIDTH] ^ cy[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_add_minus.sv
// Self-checking bench for add_minus (WIDTH=4): directed table, exhaustive sweep,
// and reset corner cases, with expected results queued at drive time.
module tb_add_minus;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic         m;
  logic [W-1:0] S;
  logic         c, v;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    string        name;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    string        name;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[5];

  add_minus #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .m   (m),
    .S   (S),
    .c   (c),
    .v   (v)
  );

  always #5 clk = ~clk;

  // Independent reference: integer arithmetic for carry, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic mm, input string nm);
    exp_t e;
    int   ua, ub, us, sa, sbv, r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sbv = int'($signed(b));
    if (mm) begin
      us = ua - ub;
      r  = sa - sbv;
      e.c = (ua >= ub);
    end else begin
      us = ua + ub;
      r  = sa + sbv;
      e.c = (us >= 16);
    end
    e.s = W'(us & 15);
    e.v = (r > 7) || (r < -8);
    e.name = nm;
    return e;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] es, input logic ec,
                       input logic ev);
    n_vec++;
    if (S !== es || c !== ec || v !== ev) begin
      n_err++;
      $display("FAIL %s: got S=%b c=%b v=%b, expected S=%b c=%b v=%b",
               nm, S, c, v, es, ec, ev);
    end
  endtask

  // Drive one operand set between edges, queue its expectation, check after the edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic mm,
                       input exp_t e);
    exp_t got;
    @(negedge clk);
    A = a;
    B = b;
    m = mm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      got = sb_q.pop_front();
      check(got.name, got.s, got.c, got.v);
    end
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rm;

    tbl[0] = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, "add_carry"};
    tbl[1] = '{4'b0100, 4'b0111, 1'b0, 4'b1011, 1'b0, 1'b1, "add_overflow"};
    tbl[2] = '{4'b0000, 4'b1111, 1'b1, 4'b0001, 1'b0, 1'b0, "sub_borrow"};
    tbl[3] = '{4'b1101, 4'b1010, 1'b1, 4'b0011, 1'b1, 1'b0, "sub_no_borrow"};
    tbl[4] = '{4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b1, "sub_overflow"};

    // Reset held across edges with nonzero operands.
    rst = 1'b1;
    A = 4'b1111;
    B = 4'b1111;
    m = 1'b0;
    #2;
    check("reset_initial", 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      e.s = tbl[i].s;
      e.c = tbl[i].c;
      e.v = tbl[i].v;
      e.name = tbl[i].name;
      apply(tbl[i].a, tbl[i].b, tbl[i].m, e);
    end

    // Asynchronous reset between edges after a nonzero result.
    apply(4'b1111, 4'b1111, 1'b0, model(4'b1111, 4'b1111, 1'b0, "pre_async_reset"));
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_async_hold", 4'b0000, 1'b0, 1'b0);
    #2;
    rst = 1'b0;

    // Mode toggles alone: same operands, add then subtract.
    apply(4'b0101, 4'b0011, 1'b0, model(4'b0101, 4'b0011, 1'b0, "m_toggle_add"));
    apply(4'b0101, 4'b0011, 1'b1, model(4'b0101, 4'b0011, 1'b1, "m_toggle_sub"));

    // Exhaustive sweep, one per cycle, with a reset pulse partway through.
    for (int i = 0; i < 512; i++) begin
      ra = W'(i & 15);
      rb = W'((i >> 4) & 15);
      rm = 1'((i >> 8) & 1);
      apply(ra, rb, rm, model(ra, rb, rm, $sformatf("sweep_%0d", i)));
      if (i == 300) begin
        #1;
        rst = 1'b1;
        #1;
        check("reset_midstream", 4'b0000, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
